// File: rtl/alu_div_sequencer_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer:
// funct3[1:0] op encodings, FSM states and small op-decode helpers.
package alu_div_sequencer_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !((op == OpDivu) || (op == OpRemu));
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/alu_div_sequencer_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep it if non-negative.
module alu_div_sequencer_div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  logic [Width:0] shifted;
  logic [Width:0] trial;
  logic           trial_neg;

  always_comb begin
    // Keep the remainder MSB so divisors above 2^(Width-1) still divide correctly.
    shifted   = {rem_i, quo_i[Width-1]};
    trial     = shifted - {1'b0, divisor_i};
    trial_neg = trial[Width];
    rem_o     = trial_neg ? shifted[Width-1:0] : trial[Width-1:0];
    quo_o     = {quo_i[Width-2:0], ~trial_neg};
  end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside the execute-stage ALU:
// magnitude restoring division over XLEN cycles, then a one-cycle sign fix-up.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed;
  logic            in_rem;
  logic [XLEN-1:0] abs_dividend;
  logic [XLEN-1:0] abs_divisor;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  alu_div_sequencer_div_step #(
    .Width (XLEN)
  ) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    in_signed    = op_is_signed(op_i);
    in_rem       = op_is_rem(op_i);
    abs_dividend = (in_signed && dividend_i[XLEN-1]) ? ('0 - dividend_i) : dividend_i;
    abs_divisor  = (in_signed && divisor_i[XLEN-1])  ? ('0 - divisor_i)  : divisor_i;
  end

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (kill_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            is_rem_d  = in_rem;
            neg_quo_d = in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            neg_rem_d = in_signed && dividend_i[XLEN-1];
            if (divisor_i == '0) begin
              result_d = in_rem ? dividend_i : '1;
              state_d  = StDone;
            end else if (in_signed && (dividend_i == MinNeg) && (divisor_i == '1)) begin
              result_d = in_rem ? '0 : MinNeg;
              state_d  = StDone;
            end else begin
              rem_d   = '0;
              quo_d   = abs_dividend;
              div_d   = abs_divisor;
              cnt_d   = CntW'(XLEN - 1);
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StFix;
          end
        end
        StFix: begin
          if (is_rem_q) begin
            result_d = neg_rem_q ? ('0 - rem_q) : rem_q;
          end else begin
            result_d = neg_quo_q ? ('0 - quo_q) : quo_q;
          end
          state_d = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // A flush landing on the DONE cycle must still swallow the pulse.
  assign busy_o   = (state_q == StCalc) || (state_q == StFix);
  assign valid_o  = (state_q == StDone) && !kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer: hand-computed quotients/remainders,
// latency and busy-length checks, kill, ignored starts and asynchronous reset.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        kill_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_vec;
  int n_err;

  alu_div_sequencer #(
    .XLEN (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it until valid (bounded). Latency counts the
  // start-sampling cycle, so a special case reports 1 and a full divide 34.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output logic [31:0] res, output int lat,
                        output int nbusy);
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat     = 0;
    nbusy   = 0;
    res     = '0;
    for (int k = 0; k < 60; k++) begin
      if (busy_o) nbusy++;
      if (valid_o) begin
        lat = k + 1;
        res = result_o;
        break;
      end
      if (noise && (k == 5 || k == 20)) begin
        start_i    = 1'b1;
        op_i       = OpDiv;
        dividend_i = 32'd1;
        divisor_i  = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit noise, input logic [31:0] exp_res,
                       input int exp_lat, input int exp_busy);
    logic [31:0] res;
    int          lat;
    int          nbusy;
    run_op(op, a, b, noise, res, lat, nbusy);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int vcount;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    op_i       = OpDiv;
    dividend_i = '0;
    divisor_i  = '0;
    kill_i     = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back normal ops; the second gets stray start pulses while busy.
    do_op("divu_100_7", OpDivu, 32'd100, 32'd7, 1'b0, 32'd14, 34, 33);
    do_op("remu_100_7", OpRemu, 32'd100, 32'd7, 1'b1, 32'd2, 34, 33);
    do_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 34, 33);
    do_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34, 33);
    do_op("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 34, 33);
    do_op("div_5_0", OpDiv, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1, 0);
    do_op("remu_5_0", OpRemu, 32'd5, 32'd0, 1'b0, 32'd5, 1, 0);

    // Kill in CALC cycle 10: back to IDLE, no pulse, last result (5) kept.
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = OpDivu;
    dividend_i = 32'd1000;
    divisor_i  = 32'd10;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    check("kill_busy", {31'd0, busy_o}, 32'd0);
    check("kill_valid", {31'd0, valid_o}, 32'd0);
    check("kill_result", result_o, 32'd5);
    @(negedge clk);
    kill_i = 1'b0;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (valid_o || busy_o) vcount++;
    end
    check("kill_quiet", 32'(vcount), 32'd0);
    do_op("divu_9_3", OpDivu, 32'd9, 32'd3, 1'b0, 32'd3, 34, 33);

    do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0);
    do_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1, 0);

    // Asynchronous reset mid-CALC clears outputs without waiting for a clock.
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = OpDivu;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 34, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
